// File: rtl/motor_vol_ramp_sched.sv
// motor_vol_ramp_sched: fixed-priority scheduler sharing the slow-ascent ramp between safety, host and scan.
// Optional abort-on-timeout built when RAMP_TIMEOUT_EN is defined. Rev 1.0.
`default_nettype none

module motor_vol_ramp_sched #(
    parameter real         TCQ             = 0.1,
    parameter int          MOTOR_VOL       = 16,
    parameter int          SETTLE_UPDATES  = 4,
    parameter int          TIMEOUT_UPDATES = 60000,
    parameter logic [15:0] DEF_GRADIENT    = 16'd1,
    parameter logic [15:0] DEF_PERIOD      = 16'd12207
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [2:0]             req_i,
    input  logic [3*MOTOR_VOL-1:0] tgt_vol_i,
    input  logic [47:0]            grad_i,
    input  logic [47:0]            period_i,
    output logic [2:0]             gnt_o,
    output logic [2:0]             done_o,
    output logic                   ramp_data_en_o,
    output logic [MOTOR_VOL-1:0]   ramp_data_o,
    output logic [15:0]            ramp_gradient_o,
    output logic [15:0]            ramp_period_o,
    input  logic                   ramp_en_i,
    input  logic [MOTOR_VOL-1:0]   ramp_vol_i,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RAMP   = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;
    localparam logic [3:0] c_SETTLE = 4'(SETTLE_UPDATES);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [2:0]           r_gnt,    w_gnt_nxt;
    logic [2:0]           r_done,   w_done_nxt;
    logic                 r_den,    w_den_nxt;
    logic [MOTOR_VOL-1:0] r_data,   w_data_nxt;
    logic [15:0]          r_grad,   w_grad_nxt;
    logic [15:0]          r_period, w_period_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic [3:0]           r_settle, w_settle_nxt;
    logic [3:0]           w_settle_inc;

    logic [2:0]           w_win_onehot;
    logic [MOTOR_VOL-1:0] w_win_tgt;
    logic [15:0]          w_win_grad;
    logic [15:0]          w_win_period;
    logic                 w_grant;
    logic                 w_strobe;
    logic                 w_on_tgt;
    logic                 w_preempt;
    logic                 w_settle_hit;
    logic                 w_tmo_hit;
    logic                 w_unused_tcq;

    assign w_unused_tcq = (TCQ > 0.0);

    // Lowest set request index wins.
    always_comb begin
        w_win_onehot = 3'b100;
        w_win_tgt    = tgt_vol_i[2*MOTOR_VOL +: MOTOR_VOL];
        w_win_grad   = grad_i[32 +: 16];
        w_win_period = period_i[32 +: 16];
        if (req_i[0]) begin
            w_win_onehot = 3'b001;
            w_win_tgt    = tgt_vol_i[0 +: MOTOR_VOL];
            w_win_grad   = grad_i[0 +: 16];
            w_win_period = period_i[0 +: 16];
        end else if (req_i[1]) begin
            w_win_onehot = 3'b010;
            w_win_tgt    = tgt_vol_i[MOTOR_VOL +: MOTOR_VOL];
            w_win_grad   = grad_i[16 +: 16];
            w_win_period = period_i[16 +: 16];
        end
    end

    assign w_grant      = (r_state == c_IDLE) && (|req_i);
    assign w_strobe     = (r_state == c_RAMP) && ramp_en_i;
    assign w_on_tgt     = (ramp_vol_i == r_data);
    assign w_preempt    = (r_state == c_RAMP) && req_i[0] && !r_gnt[0];
    assign w_settle_inc = (r_settle == 4'hF) ? r_settle : r_settle + 4'd1;
    assign w_settle_hit = w_strobe && w_on_tgt && (w_settle_inc >= c_SETTLE);

`ifdef RAMP_TIMEOUT_EN
    localparam logic [15:0] c_TMO = 16'(TIMEOUT_UPDATES);

    logic [15:0] r_tmo_cnt;
    logic        r_timeout;

    assign w_tmo_hit = w_strobe && ((r_tmo_cnt + 16'd1) == c_TMO);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tmo_cnt <= 16'd0;
            r_timeout <= 1'b0;
        end else if (w_grant) begin
            r_tmo_cnt <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_strobe) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            // Preemption and a genuine settle both outrank the abort.
            if (w_tmo_hit && !w_preempt && !w_settle_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign timeout_o    = 1'b0;
    assign w_unused_tmo = ^(16'(TIMEOUT_UPDATES));
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (|req_i) begin
                    w_state_nxt = c_RAMP;
                end
            end
            c_RAMP: begin
                if (w_preempt) begin
                    w_state_nxt = c_IDLE;
                end else if (w_settle_hit) begin
                    w_state_nxt = c_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = 3'b000;
        w_den_nxt    = 1'b0;
        w_data_nxt   = r_data;
        w_grad_nxt   = r_grad;
        w_period_nxt = r_period;
        w_settle_nxt = r_settle;
        case (r_state)
            c_IDLE: begin
                if (w_grant) begin
                    w_gnt_nxt    = w_win_onehot;
                    w_den_nxt    = 1'b1;
                    w_data_nxt   = w_win_tgt;
                    w_grad_nxt   = (w_win_grad == 16'd0) ? 16'd1 : w_win_grad;
                    w_period_nxt = (w_win_period == 16'd0) ? 16'd1 : w_win_period;
                    w_settle_nxt = 4'd0;
                end
            end
            c_RAMP: begin
                if (w_preempt) begin
                    w_gnt_nxt = 3'b000;
                end else if (w_settle_hit) begin
                    w_gnt_nxt  = 3'b000;
                    w_done_nxt = r_gnt;
                end else if (w_tmo_hit) begin
                    w_gnt_nxt = 3'b000;
                end else if (w_strobe) begin
                    w_settle_nxt = w_on_tgt ? w_settle_inc : 4'd0;
                end
            end
            default: w_gnt_nxt = 3'b000;
        endcase
        w_busy_nxt = (w_state_nxt != c_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_gnt    <= 3'b000;
            r_done   <= 3'b000;
            r_den    <= 1'b0;
            r_data   <= '0;
            r_grad   <= DEF_GRADIENT;
            r_period <= DEF_PERIOD;
            r_busy   <= 1'b0;
            r_settle <= 4'd0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_den    <= w_den_nxt;
            r_data   <= w_data_nxt;
            r_grad   <= w_grad_nxt;
            r_period <= w_period_nxt;
            r_busy   <= w_busy_nxt;
            r_settle <= w_settle_nxt;
        end
    end

    assign gnt_o           = r_gnt;
    assign done_o          = r_done;
    assign ramp_data_en_o  = r_den;
    assign ramp_data_o     = r_data;
    assign ramp_gradient_o = r_grad;
    assign ramp_period_o   = r_period;
    assign busy_o          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_motor_vol_ramp_sched.sv
// tb_motor_vol_ramp_sched: directed bench with a behavioural ramp and grant/done scoreboard queues.
`default_nettype none

module tb_motor_vol_ramp_sched;

    localparam int SETTLE = 4;
    localparam int TMO    = 8;

    typedef struct packed {
        logic [2:0]  gnt;
        logic [15:0] data;
        logic [15:0] grad;
        logic [15:0] period;
    } gnt_t;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [2:0]  req_i;
    logic [47:0] tgt_vol_i, grad_i, period_i;
    logic        ramp_en_i;
    logic [15:0] ramp_vol_i;
    wire  [2:0]  gnt_o, done_o;
    wire         ramp_data_en_o, busy_o, timeout_o;
    wire  [15:0] ramp_data_o, ramp_gradient_o, ramp_period_o;

    gnt_t       q_gnt[$];
    logic [2:0] q_done[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_done   = 0;
    int         m_ontgt, m_strobes, m_div;
    logic       m_active, m_freeze, prev_den;
    logic [15:0] m_tgt;

    always #5 clk = ~clk;

    motor_vol_ramp_sched #(
        .MOTOR_VOL      (16),
        .SETTLE_UPDATES (SETTLE),
        .TIMEOUT_UPDATES(TMO)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .req_i          (req_i),
        .tgt_vol_i      (tgt_vol_i),
        .grad_i         (grad_i),
        .period_i       (period_i),
        .gnt_o          (gnt_o),
        .done_o         (done_o),
        .ramp_data_en_o (ramp_data_en_o),
        .ramp_data_o    (ramp_data_o),
        .ramp_gradient_o(ramp_gradient_o),
        .ramp_period_o  (ramp_period_o),
        .ramp_en_i      (ramp_en_i),
        .ramp_vol_i     (ramp_vol_i),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input int k, input logic [15:0] t, input logic [15:0] g, input logic [15:0] p);
        tgt_vol_i[k*16 +: 16] = t;
        grad_i[k*16 +: 16]    = g;
        period_i[k*16 +: 16]  = p;
    endtask

    task automatic expect_grant(input logic [2:0] g, input logic [15:0] d, input logic [15:0] gr, input logic [15:0] p);
        gnt_t e;
        e.gnt = g; e.data = d; e.grad = gr; e.period = p;
        q_gnt.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (done_o == 3'b000 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {31'd0, done_o != 3'b000}, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt"},    gnt_o, 0);
        chk({tag, "_done"},   done_o, 0);
        chk({tag, "_den"},    ramp_data_en_o, 0);
        chk({tag, "_data"},   ramp_data_o, 0);
        chk({tag, "_grad"},   ramp_gradient_o, 1);
        chk({tag, "_period"}, ramp_period_o, 12207);
        chk({tag, "_busy"},   busy_o, 0);
        chk({tag, "_tmo"},    timeout_o, 0);
    endtask

    // Behavioural ramp plus output monitor; sampling precedes driving each cycle.
    initial begin
        gnt_t e;
        int   d;
`ifdef RAMP_TIMEOUT_EN
        logic prev_to;
        prev_to = 1'b0;
`endif
        ramp_en_i = 1'b0; ramp_vol_i = 16'd0; m_active = 1'b0; m_freeze = 1'b0;
        m_ontgt = 0; m_strobes = 0; m_div = 0; prev_den = 1'b0; m_tgt = 16'd0;
        forever begin
            @(negedge clk);
            if (ramp_data_en_o) begin
                chk("den_width", {31'd0, prev_den}, 0);
                if (q_gnt.size() == 0) begin
                    chk("gnt_unexpected", {31'd0, ramp_data_en_o}, 0);
                end else begin
                    e = q_gnt.pop_front();
                    chk("grant_vec",    gnt_o, e.gnt);
                    chk("grant_data",   ramp_data_o, e.data);
                    chk("grant_grad",   ramp_gradient_o, e.grad);
                    chk("grant_period", ramp_period_o, e.period);
                end
                m_tgt = ramp_data_o; m_ontgt = 0; m_strobes = 0; m_div = 0; m_active = 1'b1;
            end
            prev_den = ramp_data_en_o;
            if (done_o != 3'b000) begin
                n_done++;
                if (q_done.size() == 0) begin
                    chk("done_unexpected", done_o, 0);
                end else begin
                    chk("done_vec", done_o, q_done.pop_front());
                    chk("done_settle_strobes", m_ontgt, SETTLE);
                end
            end
`ifdef RAMP_TIMEOUT_EN
            if (timeout_o && !prev_to) chk("timeout_strobes", m_strobes, TMO);
            prev_to = timeout_o;
`endif
            ramp_en_i = 1'b0;
            if (m_freeze) ramp_vol_i = 16'd0;
            if (m_active) begin
                m_div++;
                if (m_div >= int'(ramp_period_o)) begin
                    m_div = 0;
                    ramp_en_i = 1'b1;
                    m_strobes++;
                    if (!m_freeze) begin
                        d = int'(m_tgt) - int'(ramp_vol_i);
                        if (d > int'(ramp_gradient_o))       ramp_vol_i = ramp_vol_i + ramp_gradient_o;
                        else if (-d > int'(ramp_gradient_o)) ramp_vol_i = ramp_vol_i - ramp_gradient_o;
                        else                                 ramp_vol_i = m_tgt;
                    end
                    if (ramp_vol_i == m_tgt) m_ontgt++;
                    else                     m_ontgt = 0;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int exp_done;
        rst_n_i = 1'b0; req_i = 3'b000;
        tgt_vol_i = '0; grad_i = '0; period_i = '0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n_i = 1'b1;
        @(negedge clk);

        // Host alone.
        set_job(1, 16'd1000, 16'd100, 16'd10);
        expect_grant(3'b010, 16'd1000, 16'd100, 16'd10);
        q_done.push_back(3'b010);
        req_i = 3'b010;
        @(negedge clk);
        chk("t1_busy", {31'd0, busy_o}, 1);
        wait_done("t1_done_seen");
        chk("t1_gnt_drop", gnt_o, 0);
        req_i = 3'b000;
        @(negedge clk);
        chk("t1_idle_busy", {31'd0, busy_o}, 0);

        // Host and scan together: host first, scan after host completes.
        set_job(1, 16'd2000, 16'd250, 16'd2);
        set_job(2, 16'd3000, 16'd500, 16'd3);
        expect_grant(3'b010, 16'd2000, 16'd250, 16'd2);
        expect_grant(3'b100, 16'd3000, 16'd500, 16'd3);
        q_done.push_back(3'b010);
        q_done.push_back(3'b100);
        req_i = 3'b110;
        wait_done("t2_host_done_seen");
        req_i = 3'b100;
        wait_done("t2_scan_done_seen");
        req_i = 3'b000;

        // Safety preempts a scan ramp in flight.
        set_job(2, 16'd5000, 16'd100, 16'd2);
        expect_grant(3'b100, 16'd5000, 16'd100, 16'd2);
        req_i = 3'b100;
        i = 0;
        while (ramp_vol_i < 16'd3500 && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk("t3_scan_progress", {31'd0, ramp_vol_i >= 16'd3500}, 1);
        set_job(0, 16'd0, 16'd500, 16'd1);
        expect_grant(3'b001, 16'd0, 16'd500, 16'd1);
        expect_grant(3'b100, 16'd5000, 16'd100, 16'd2);
        q_done.push_back(3'b001);
        q_done.push_back(3'b100);
        req_i = 3'b101;
        @(negedge clk);
        chk("t3_gap_gnt", gnt_o, 0);
        chk("t3_gap_done", done_o, 0);
        @(negedge clk);
        chk("t3_safety_gnt", gnt_o, 3'b001);
        wait_done("t3_safety_done_seen");
        req_i = 3'b100;
        wait_done("t3_scan_done_seen");
        req_i = 3'b000;

        // Zero gradient and period clamp to one.
        set_job(1, 16'd5000, 16'd0, 16'd0);
        expect_grant(3'b010, 16'd5000, 16'd1, 16'd1);
        q_done.push_back(3'b010);
        req_i = 3'b010;
        wait_done("t4_done_seen");
        req_i = 3'b000;
        exp_done = 6;

        // Reset mid-ramp aborts silently.
        set_job(1, 16'd0, 16'd10, 16'd5);
        expect_grant(3'b010, 16'd0, 16'd10, 16'd5);
        req_i = 3'b010;
        repeat (20) @(negedge clk);
        chk("t5_busy", {31'd0, busy_o}, 1);
        rst_n_i = 1'b0;
        req_i = 3'b000;
        @(negedge clk);
        check_reset("t5_rst");
        rst_n_i = 1'b1;
        repeat (50) @(negedge clk);

`ifdef RAMP_TIMEOUT_EN
        // Ramp stuck at zero never reaches 500: abort after TMO strobes.
        m_freeze = 1'b1;
        set_job(1, 16'd500, 16'd10, 16'd2);
        expect_grant(3'b010, 16'd500, 16'd10, 16'd2);
        req_i = 3'b010;
        i = 0;
        @(negedge clk);
        while (!timeout_o && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("t6_timeout_set", {31'd0, timeout_o}, 1);
        chk("t6_gnt", gnt_o, 0);
        chk("t6_busy", {31'd0, busy_o}, 0);
        chk("t6_done", done_o, 0);
        req_i = 3'b000;
        @(negedge clk);
        chk("t6_timeout_sticky", {31'd0, timeout_o}, 1);
        m_freeze = 1'b0;
        set_job(1, 16'd0, 16'd1, 16'd1);
        expect_grant(3'b010, 16'd0, 16'd1, 16'd1);
        q_done.push_back(3'b010);
        req_i = 3'b010;
        @(negedge clk);
        chk("t6_timeout_clear", {31'd0, timeout_o}, 0);
        wait_done("t6_done_seen");
        req_i = 3'b000;
        exp_done = 7;
`endif

        repeat (5) @(negedge clk);
        chk("end_done_count", n_done, exp_done);
        chk("end_gnt_queue", q_gnt.size(), 0);
        chk("end_done_queue", q_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
